multicycle_control: RTL and testbench

Control FSM for the multicycle RV32I core, driving the ALU, register file, PC, instruction register and memory port. It is the producer side of the ALU op_code interface: it decodes the instruction register and issues `ALUOP_*` codes plus operand selects each cycle. It also sequences instruction fetch and load/store through a req/ready memory handshake.

---
 rtl/multicycle_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core: decodes the instruction register into
// ALU op codes, operand selects and write strobes, and sequences fetch/load/store.

`ifndef ALUOP_ADD
`define ALUOP_ADD  4'd0
`define ALUOP_SUB  4'd1
`define ALUOP_SLL  4'd2
`define ALUOP_SLT  4'd3
`define ALUOP_SLTU 4'd4
`define ALUOP_XOR  4'd5
`define ALUOP_SRL  4'd6
`define ALUOP_SRA  4'd7
`define ALUOP_OR   4'd8
`define ALUOP_AND  4'd9
`define ALUOP_SRC1 4'd10
`endif

module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lsb,
    input  logic        mem_ready,
    output logic [3:0]  alu_op_code,
    output logic [1:0]  alu_src_a_sel,
    output logic [1:0]  alu_src_b_sel,
    output logic [2:0]  imm_sel,
    output logic        pc_src_sel,
    output logic        pc_we,
    output logic        pc_lsb_clr,
    output logic        ir_we,
    output logic        adr_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;
    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU_OUT = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC      = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALU_WB, S_MEM_ADDR,
        S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_ILLEGAL
    } state_t;

    state_t     state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       br_legal;
    logic       br_taken;
    logic [3:0] br_op;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7_b5         = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? `ALUOP_SUB : `ALUOP_ADD;
            3'b001:  return `ALUOP_SLL;
            3'b010:  return `ALUOP_SLT;
            3'b011:  return `ALUOP_SLTU;
            3'b100:  return `ALUOP_XOR;
            3'b101:  return alt ? `ALUOP_SRA : `ALUOP_SRL;
            3'b110:  return `ALUOP_OR;
            default: return `ALUOP_AND;
        endcase
    endfunction

    // funct3[2] picks the less-than flag over the zero flag; funct3[0] inverts the sense
    assign br_legal = (funct3[2:1] != 2'b01);
    assign br_taken = br_legal && ((funct3[2] ? alu_lsb : alu_zero) ^ funct3[0]);
    always_comb begin
        case (funct3[2:1])
            2'b00:   br_op = `ALUOP_SUB;
            2'b10:   br_op = `ALUOP_SLT;
            2'b11:   br_op = `ALUOP_SLTU;
            default: br_op = `ALUOP_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:     if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OPC_OP:              state <= S_EXEC_R;
                        OPC_OP_IMM:          state <= S_EXEC_I;
                        OPC_LOAD, OPC_STORE: state <= S_MEM_ADDR;
                        OPC_BRANCH:          state <= S_BRANCH;
                        OPC_JAL:             state <= S_JAL;
                        OPC_JALR:            state <= S_JALR;
                        OPC_LUI, OPC_AUIPC:  state <= S_EXEC_U;
                        OPC_FENCE:           state <= S_FETCH;
                        default:             state <= S_ILLEGAL;
                    endcase
                end
                S_EXEC_R, S_EXEC_I, S_EXEC_U:      state <= S_ALU_WB;
                S_ALU_WB, S_MEM_WB, S_JAL, S_JALR: state <= S_FETCH;
                S_MEM_ADDR:  state <= opcode[5] ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
                S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
                S_BRANCH:    state <= br_legal ? S_FETCH : S_ILLEGAL;
                default:     state <= S_ILLEGAL;
            endcase
        end
    end

    // Outputs are forced quiet while rst_n is low so nothing is written in the reset cycle
    always_comb begin
        alu_op_code   = `ALUOP_ADD;
        alu_src_a_sel = SRC_A_PC;
        alu_src_b_sel = SRC_B_RS2;
        imm_sel       = IMM_I;
        pc_src_sel    = 1'b0;
        pc_we         = 1'b0;
        pc_lsb_clr    = 1'b0;
        ir_we         = 1'b0;
        adr_sel       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = WB_ALU_OUT;
        retire        = 1'b0;
        illegal       = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req       = 1'b1;
                    alu_src_b_sel = SRC_B_FOUR;
                    ir_we         = mem_ready;
                    pc_we         = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a_sel = SRC_A_OLD_PC;
                    alu_src_b_sel = SRC_B_IMM;
                    if (opcode == OPC_BRANCH)   imm_sel = IMM_B;
                    else if (opcode == OPC_JAL) imm_sel = IMM_J;
                    retire        = (opcode == OPC_FENCE);
                end
                S_EXEC_R: begin
                    alu_src_a_sel = SRC_A_RS1;
                    alu_op_code   = arith_op(funct3, funct7_b5);
                end
                S_EXEC_I: begin
                    alu_src_a_sel = SRC_A_RS1;
                    alu_src_b_sel = SRC_B_IMM;
                    alu_op_code   = arith_op(funct3, funct7_b5 && (funct3 == 3'b101));
                end
                S_EXEC_U: begin
                    alu_src_b_sel = SRC_B_IMM;
                    imm_sel       = IMM_U;
                    if (opcode == OPC_LUI) alu_op_code   = `ALUOP_SRC1;
                    else                   alu_src_a_sel = SRC_A_OLD_PC;
                end
                S_ALU_WB: begin
                    rf_we  = 1'b1;
                    retire = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a_sel = SRC_A_RS1;
                    alu_src_b_sel = SRC_B_IMM;
                    imm_sel       = opcode[5] ? IMM_S : IMM_I;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    adr_sel = 1'b1;
                end
                S_MEM_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = WB_MEM;
                    retire = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_sel = 1'b1;
                    retire  = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a_sel = SRC_A_RS1;
                    alu_op_code   = br_op;
                    pc_we         = br_taken;
                    pc_src_sel    = br_taken;
                    retire        = br_legal;
                end
                S_JAL: begin
                    pc_we      = 1'b1;
                    pc_src_sel = 1'b1;
                    rf_we      = 1'b1;
                    wb_sel     = WB_PC;
                    retire     = 1'b1;
                end
                S_JALR: begin
                    alu_src_a_sel = SRC_A_RS1;
                    alu_src_b_sel = SRC_B_IMM;
                    pc_we         = 1'b1;
                    pc_lsb_clr    = 1'b1;
                    rf_we         = 1'b1;
                    wb_sel        = WB_PC;
                    retire        = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push the
// expected per-cycle control word; a negedge monitor pops and compares it.

module tb_multicycle_control;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_SRC1 = 4'd10;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic       pc_src;
        logic       pc_we;
        logic       lsb_clr;
        logic       ir_we;
        logic       adr;
        logic       req;
        logic       we;
        logic       rf_we;
        logic [1:0] wb;
        logic       retire;
        logic       illegal;
    } out_t;

    typedef struct {
        out_t  v;
        string name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero, alu_lsb, mem_ready;
    logic [3:0]  alu_op_code;
    logic [1:0]  alu_src_a_sel, alu_src_b_sel, wb_sel;
    logic [2:0]  imm_sel;
    logic        pc_src_sel, pc_we, pc_lsb_clr, ir_we, adr_sel, mem_req, mem_we, rf_we;
    logic        retire, illegal;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
        .mem_ready(mem_ready), .alu_op_code(alu_op_code), .alu_src_a_sel(alu_src_a_sel),
        .alu_src_b_sel(alu_src_b_sel), .imm_sel(imm_sel), .pc_src_sel(pc_src_sel),
        .pc_we(pc_we), .pc_lsb_clr(pc_lsb_clr), .ir_we(ir_we), .adr_sel(adr_sel),
        .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel),
        .retire(retire), .illegal(illegal)
    );

    // Monitor: pop one expected control word per cycle, away from the active edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            out_t got;
            e   = q.pop_front();
            got = {alu_op_code, alu_src_a_sel, alu_src_b_sel, imm_sel, pc_src_sel, pc_we,
                   pc_lsb_clr, ir_we, adr_sel, mem_req, mem_we, rf_we, wb_sel, retire, illegal};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s got=%b required=%b", e.name, got, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic out_t e_zero();
        out_t o = '0;
        return o;
    endfunction
    function automatic out_t e_fetch(input logic rdy);
        out_t o = '0;
        o.req = 1'b1; o.b = 2'd2; o.ir_we = rdy; o.pc_we = rdy;
        return o;
    endfunction
    function automatic out_t e_decode(input logic [2:0] imm);
        out_t o = '0;
        o.a = 2'd1; o.b = 2'd1; o.imm = imm;
        return o;
    endfunction
    function automatic out_t e_exec_r(input logic [3:0] op);
        out_t o = '0;
        o.a = 2'd2; o.b = 2'd0; o.op = op;
        return o;
    endfunction
    function automatic out_t e_exec_i(input logic [3:0] op);
        out_t o = '0;
        o.a = 2'd2; o.b = 2'd1; o.imm = 3'd0; o.op = op;
        return o;
    endfunction
    function automatic out_t e_exec_u(input logic lui);
        out_t o = '0;
        o.b = 2'd1; o.imm = 3'd3;
        if (lui) o.op = OP_SRC1;
        else     o.a  = 2'd1;
        return o;
    endfunction
    function automatic out_t e_alu_wb();
        out_t o = '0;
        o.rf_we = 1'b1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mem_addr(input logic store);
        out_t o = '0;
        o.a = 2'd2; o.b = 2'd1; o.imm = store ? 3'd1 : 3'd0;
        return o;
    endfunction
    function automatic out_t e_mem_read();
        out_t o = '0;
        o.req = 1'b1; o.adr = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mem_wb();
        out_t o = '0;
        o.rf_we = 1'b1; o.wb = 2'd1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mem_write(input logic rdy);
        out_t o = '0;
        o.req = 1'b1; o.we = 1'b1; o.adr = 1'b1; o.retire = rdy;
        return o;
    endfunction
    function automatic out_t e_branch(input logic [3:0] op, input logic taken);
        out_t o = '0;
        o.a = 2'd2; o.b = 2'd0; o.op = op; o.pc_we = taken; o.pc_src = taken; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_jal();
        out_t o = '0;
        o.pc_we = 1'b1; o.pc_src = 1'b1; o.rf_we = 1'b1; o.wb = 2'd2; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_jalr();
        out_t o = '0;
        o.a = 2'd2; o.b = 2'd1; o.pc_we = 1'b1; o.lsb_clr = 1'b1;
        o.rf_we = 1'b1; o.wb = 2'd2; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_illegal();
        out_t o = '0;
        o.illegal = 1'b1;
        return o;
    endfunction

    task automatic step(input logic [31:0] i, input logic z, input logic l, input logic r,
                        input out_t e, input string n);
        instr = i; alu_zero = z; alu_lsb = l; mem_ready = r;
        q.push_back('{v: e, name: n});
        @(posedge clk);
        #1;
    endtask

    task automatic alu_instr(input logic [31:0] i, input out_t exec, input string n);
        step(i, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), {n, "_fetch"});
        step(i, 1'b0, 1'b0, 1'b0, e_decode(3'd0), {n, "_decode"});
        step(i, 1'b0, 1'b0, 1'b0, exec, {n, "_exec"});
        step(i, 1'b0, 1'b0, 1'b0, e_alu_wb(), {n, "_wb"});
    endtask

    task automatic branch_instr(input logic [31:0] i, input logic z, input logic l,
                                input logic [3:0] op, input logic taken, input string n);
        step(i, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), {n, "_fetch"});
        step(i, 1'b0, 1'b0, 1'b0, e_decode(3'd2), {n, "_decode"});
        step(i, z, l, 1'b0, e_branch(op, taken), {n, "_branch"});
    endtask

    logic [3:0] base_op [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};

    initial begin
        rst_n = 1'b0; instr = '0; alu_zero = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        step(32'h0, 1'b0, 1'b0, 1'b1, e_zero(), "reset_quiet");
        rst_n = 1'b1;

        alu_instr(32'h002081B3, e_exec_r(OP_ADD), "add");
        alu_instr(32'h402081B3, e_exec_r(OP_SUB), "sub");

        step(32'h00108093, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), "fetch_wait");
        alu_instr(32'h00108093, e_exec_i(OP_ADD), "addi");

        // Load with three wait states in MEM_READ: retire lands in cycle 8
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "lw_fetch");
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_decode(3'd0), "lw_decode");
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_mem_addr(1'b0), "lw_addr");
        for (int k = 0; k < 3; k++)
            step(32'h0000A183, 1'b0, 1'b0, 1'b0, e_mem_read(), "lw_read_wait");
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_mem_read(), "lw_read_done");
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_mem_wb(), "lw_wb");

        step(32'h0020A023, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "sw_fetch");
        step(32'h0020A023, 1'b0, 1'b0, 1'b1, e_decode(3'd0), "sw_decode");
        step(32'h0020A023, 1'b0, 1'b0, 1'b1, e_mem_addr(1'b1), "sw_addr");
        step(32'h0020A023, 1'b0, 1'b0, 1'b0, e_mem_write(1'b0), "sw_write_wait");
        step(32'h0020A023, 1'b0, 1'b0, 1'b1, e_mem_write(1'b1), "sw_write_done");

        branch_instr(32'h00208463, 1'b1, 1'b0, OP_SUB,  1'b1, "beq_taken");
        branch_instr(32'h00208463, 1'b0, 1'b1, OP_SUB,  1'b0, "beq_not");
        branch_instr(32'h0020F463, 1'b1, 1'b0, OP_SLTU, 1'b1, "bgeu_taken");
        branch_instr(32'h0020F463, 1'b0, 1'b1, OP_SLTU, 1'b0, "bgeu_not");
        branch_instr(32'h0020C463, 1'b0, 1'b1, OP_SLT,  1'b1, "blt_taken");

        step(32'h008000EF, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "jal_fetch");
        step(32'h008000EF, 1'b0, 1'b0, 1'b0, e_decode(3'd4), "jal_decode");
        step(32'h008000EF, 1'b0, 1'b0, 1'b0, e_jal(), "jal_exec");

        step(32'h000080E7, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "jalr_fetch");
        step(32'h000080E7, 1'b0, 1'b0, 1'b0, e_decode(3'd0), "jalr_decode");
        step(32'h000080E7, 1'b0, 1'b0, 1'b0, e_jalr(), "jalr_exec");

        alu_instr(32'h000001B7, e_exec_u(1'b1), "lui");
        alu_instr(32'h00000197, e_exec_u(1'b0), "auipc");
        alu_instr(32'h4020D193, e_exec_i(OP_SRA), "srai");

        for (int f3 = 0; f3 < 8; f3++) begin
            for (int alt = 0; alt < 2; alt++) begin
                logic [31:0] ri, ii;
                logic [3:0]  rop, iop;
                ri  = {1'b0, alt[0], 5'd0, 5'd2, 5'd1, f3[2:0], 5'd3, 7'b0110011};
                ii  = {1'b0, alt[0], 5'd0, 5'd2, 5'd1, f3[2:0], 5'd3, 7'b0010011};
                rop = base_op[f3];
                iop = base_op[f3];
                if (alt == 1 && f3 == 0) rop = OP_SUB;
                if (alt == 1 && f3 == 5) begin
                    rop = OP_SRA;
                    iop = OP_SRA;
                end
                alu_instr(ri, e_exec_r(rop), $sformatf("r_f3_%0d_alt%0d", f3, alt));
                alu_instr(ii, e_exec_i(iop), $sformatf("i_f3_%0d_alt%0d", f3, alt));
            end
        end

        // Reset while a load is waiting on memory: request drops, nothing written
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "rstmid_fetch");
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_decode(3'd0), "rstmid_decode");
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_mem_addr(1'b0), "rstmid_addr");
        step(32'h0000A183, 1'b0, 1'b0, 1'b0, e_mem_read(), "rstmid_read_wait");
        rst_n = 1'b0;
        step(32'h0000A183, 1'b0, 1'b0, 1'b1, e_zero(), "rstmid_reset_cycle");
        rst_n = 1'b1;
        alu_instr(32'h002081B3, e_exec_r(OP_ADD), "after_rstmid");

        step(32'h00000073, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), "ill_fetch");
        step(32'h00000073, 1'b0, 1'b0, 1'b1, e_decode(3'd0), "ill_decode");
        for (int k = 0; k < 20; k++)
            step(32'h00000073, 1'b0, 1'b0, 1'b1, e_illegal(), $sformatf("ill_hold_%0d", k));
        rst_n = 1'b0;
        step(32'h00000073, 1'b0, 1'b0, 1'b1, e_zero(), "ill_reset_cycle");
        rst_n = 1'b1;
        alu_instr(32'h402081B3, e_exec_r(OP_SUB), "after_illegal");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
